// File: rtl/sync_fifo_flex_pkg.sv
// sync_fifo_flex_pkg: shared operation encoding for sync_fifo_flex
package sync_fifo_flex_pkg;
  typedef enum logic [1:0] {OP_IDLE = 2'b00, OP_RD = 2'b01, OP_WR = 2'b10, OP_BOTH = 2'b11} fifo_op_e;
endpackage

// File: rtl/sync_fifo_defs.vh
// sync_fifo_defs: clog2 helper, count width and parameter legality check, included inside sync_fifo_flex
function automatic int clog2(input int v);
  int r;
  r = 0;
  while ((1 << r) < v) r++;
  return r;
endfunction
localparam int CNT_W = ADDR_WIDTH + 1;
if (clog2(FIFO_DEPTH) > ADDR_WIDTH || AFULL_THRESH > FIFO_DEPTH || AEMPTY_THRESH > FIFO_DEPTH) begin : g_bad_params
  $error("sync_fifo_flex: illegal FIFO_DEPTH/ADDR_WIDTH/threshold combination");
end

// File: rtl/sync_fifo_ptr.sv
// sync_fifo_ptr: modulo-DEPTH pointer; ports clk, rst_n, clr (sync zero, wins over inc), inc, ptr
module sync_fifo_ptr #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] ptr
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else ptr <= clr ? '0 : !inc ? ptr : ptr == AW'(DEPTH - 1) ? '0 : ptr + 1'b1;
endmodule

// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: single-clock FIFO with any depth, count, almost flags, flush and sticky errors
//   in : clk, rst_n (async low), clr (sync flush), wr_en, wr_data, rd_en
//   out: rd_data, full, empty, almost_full, almost_empty, count, wr_err, rd_err, ovf_sticky, udf_sticky
//   SYNC_FIFO_FWFT_EN defined: rd_data shows the head word combinationally; otherwise registered read
module sync_fifo_flex
  import sync_fifo_flex_pkg::*;
#(
  parameter int FIFO_WIDTH    = 32,
  parameter int FIFO_DEPTH    = 8,
  parameter int ADDR_WIDTH    = 3,
  parameter int AFULL_THRESH  = 6,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [FIFO_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  wr_err,
  output logic                  rd_err,
  output logic                  ovf_sticky,
  output logic                  udf_sticky
);
`include "sync_fifo_defs.vh"
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic wr_acc, rd_acc, wr_rej, rd_rej;
  fifo_op_e op;
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);
  assign wr_rej = wr_en & ~wr_acc;
  assign rd_rej = rd_en & ~rd_acc;
  assign op = clr ? OP_IDLE : fifo_op_e'({wr_acc, rd_acc});
  assign full = count == CNT_W'(FIFO_DEPTH);
  assign empty = count == '0;
  assign almost_full = count >= CNT_W'(AFULL_THRESH);
  assign almost_empty = count <= CNT_W'(AEMPTY_THRESH);
  sync_fifo_ptr #(.DEPTH(FIFO_DEPTH), .AW(ADDR_WIDTH)) u_wr_ptr (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(wr_acc), .ptr(wr_ptr)
  );
  sync_fifo_ptr #(.DEPTH(FIFO_DEPTH), .AW(ADDR_WIDTH)) u_rd_ptr (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(rd_acc), .ptr(rd_ptr)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      count      <= '0;
      wr_err     <= 1'b0;
      rd_err     <= 1'b0;
      ovf_sticky <= 1'b0;
      udf_sticky <= 1'b0;
    end else begin
      count      <= clr ? '0 : op == OP_WR ? count + 1'b1 : op == OP_RD ? count - 1'b1 : count;
      wr_err     <= ~clr & wr_rej;
      rd_err     <= ~clr & rd_rej;
      ovf_sticky <= ~clr & (ovf_sticky | wr_rej);
      udf_sticky <= ~clr & (udf_sticky | rd_rej);
    end
  always_ff @(posedge clk)
    if (wr_acc & ~clr) mem[wr_ptr] <= wr_data;
`ifdef SYNC_FIFO_FWFT_EN
  assign rd_data = mem[rd_ptr];
`else
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rd_data <= '0;
    else if (rd_acc & ~clr) rd_data <= mem[rd_ptr];
`endif
endmodule

// File: doc/sync_fifo_flex.md
Name: sync_fifo_flex

Overview:
Parametrised next-generation synchronous FIFO for single-clock datapaths. It extends the basic full/empty/error FIFO in the following ways:
- arbitrary (non-power-of-two) depth
- occupancy count output
- programmable almost-full and almost-empty thresholds
- synchronous flush
- sticky overflow/underflow status

It sits between producer and consumer stages in the same clock domain. Optional first-word-fall-through read mode.

Parameters:
FIFO_WIDTH, 32, data word width in bits (>=1)
FIFO_DEPTH, 8, number of entries, any value 2..2**ADDR_WIDTH
ADDR_WIDTH, 3, pointer width; must satisfy 2**ADDR_WIDTH >= FIFO_DEPTH
AFULL_THRESH, 6, almost_full asserts when count >= AFULL_THRESH
AEMPTY_THRESH, 2, almost_empty asserts when count <= AEMPTY_THRESH

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous flush, empties FIFO, clears sticky status
wr_en  in  1  write request
wr_data  in  FIFO_WIDTH  write data
rd_en  in  1  read request
rd_data  out  FIFO_WIDTH  read data
full  out  1  count == FIFO_DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AFULL_THRESH
almost_empty  out  1  count <= AEMPTY_THRESH
count  out  ADDR_WIDTH+1  current occupancy
wr_err  out  1  one-cycle pulse: write rejected
rd_err  out  1  one-cycle pulse: read rejected
ovf_sticky  out  1  set by any wr_err, held until clr/reset
udf_sticky  out  1  set by any rd_err, held until clr/reset

Behaviour:
- Reset (rst_n low, async):
  - pointers = 0, count = 0, empty = 1, full = 0.
  - almost_empty = 1; almost_full = (AFULL_THRESH == 0).
  - wr_err = rd_err = 0, ovf_sticky = udf_sticky = 0, rd_data = 0.
  - Storage array is not reset.
- Acceptance, evaluated on pre-edge state:
  - wr_acc = wr_en & (!full | rd_acc).
  - rd_acc = rd_en & !empty.
  - Write on a full FIFO succeeds only when a read is accepted the same cycle.
  - Read on an empty FIFO is always rejected, even with a simultaneous write.
- Write: mem[wr_ptr] <= wr_data.
- Pointer wrap: both pointers increment modulo FIFO_DEPTH (FIFO_DEPTH-1 -> 0), not modulo 2**ADDR_WIDTH.
- Count update: +1 on write only, -1 on read only, unchanged when both accepted.
- Flags and count are registered; they reflect the accepted operations one cycle after the edge.
- Errors:
  - wr_err <= wr_en & !wr_acc; rd_err <= rd_en & !rd_acc.
  - Both are registered one-cycle pulses, asserted the cycle after the rejected request.
  - A rejected operation changes no state other than the error and sticky bits.
- Standard read mode (default):
  - rd_data <= mem[rd_ptr] on rd_acc; visible the cycle after rd_en.
  - rd_data holds its last value on idle or rejected reads.
- clr:
  - Pointers and count go to 0 and stickies to 0 on the next edge; wr_en/rd_en that cycle are ignored and raise no errors.
  - rd_data holds its value.
  - clr has priority over everything except rst_n.
- Reset mid-operation: immediate async return to reset values; in-flight data is discarded.

Optional Feature:
SYNC_FIFO_FWFT_EN.
- Defined: first-word-fall-through mode.
  - rd_data is combinationally driven from mem[rd_ptr]; no output register.
  - The head word is valid whenever empty == 0; rd_en acts as a pop/acknowledge.
  - Write-to-first-data latency is 1 cycle (the same edge that deasserts empty).
  - rd_data is don't-care while empty.
- Undefined: standard registered read mode as above.
- Flags, count, and error behaviour are identical in both modes.

Decomposition:
- Shared header sync_fifo_defs.vh holds:
  - the clog2 constant function
  - the count-width localparam (ADDR_WIDTH+1)
  - the parameter-legality check: FIFO_DEPTH <= 2**ADDR_WIDTH, and both thresholds <= FIFO_DEPTH, else $error at elaboration.
- One sub-module: sync_fifo_ptr, a modulo-FIFO_DEPTH pointer counter with inc and clr inputs, instantiated twice (write and read).

Test Plan (FIFO_DEPTH=8, AFULL_THRESH=6, AEMPTY_THRESH=2; FIFO_DEPTH=6 for the wrap test):
- Reset, then write 1..8 -> count steps 1..8; almost_empty drops at count 3; almost_full rises at count 6; full=1 at count 8. A 9th write -> wr_err pulse, ovf_sticky=1, count stays 8.
- Read 8 from the full FIFO -> rd_data 1..8 in order, each the cycle after rd_en (FWFT: present before rd_en). A 9th read -> rd_err pulse, udf_sticky=1, rd_data holds 8.
- Simultaneous wr_en+rd_en when full (8 entries) -> both accepted, count stays 8, no wr_err. When empty -> write accepted, rd_err pulses, count becomes 1.
- FIFO_DEPTH=6: write/read 20 words streaming with a 3-deep backlog -> output sequence matches input exactly across pointer wrap 5->0; count never exceeds 6.
- Fill 5 entries, assert clr together with wr_en -> count=0, empty=1, stickies cleared, no wr_err. Next write 0xA5 then read returns 0xA5.
- Drop rst_n mid-burst at count 4 -> same cycle count=0, empty=1, almost_empty=1, wr_err=rd_err=0, rd_data=0.
